// File: rtl/serial_addsub_unit.sv
// Multi-cycle WIDTH-bit adder/subtractor that handles DIGIT bits per clock, LSB digit first,
// behind a valid/ready handshake on both the operand and the result side.
module serial_addsub_unit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_badParams
            $error("serial_addsub_unit: DIGIT must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CW-1:0]     r_cnt;
    logic              r_carry;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_s;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    logic [31:0]       w_base;
    logic [DIGIT-1:0]  w_aDig;
    logic [DIGIT-1:0]  w_bDig;
    logic [DIGIT:0]    w_sum;
    logic              w_msbCarryIn;
    logic              w_lastDig;
    logic [WIDTH-1:0]  w_sNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (w_lastDig) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Carry into the digit MSB is recovered from the sum bit, which also covers DIGIT == 1.
    always_comb begin
        w_base       = 32'(r_cnt) * DIGIT;
        w_aDig       = r_a[w_base +: DIGIT];
        w_bDig       = r_b[w_base +: DIGIT];
        w_sum        = {1'b0, w_aDig} + {1'b0, w_bDig} + {{DIGIT{1'b0}}, r_carry};
        w_msbCarryIn = w_sum[DIGIT-1] ^ w_aDig[DIGIT-1] ^ w_bDig[DIGIT-1];
        w_lastDig    = (r_cnt == CW'(NDIG - 1));
        w_sNext      = r_s;
        w_sNext[w_base +: DIGIT] = w_sum[DIGIT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= cin;
                r_cnt   <= '0;
            end else if (r_state == BUSY) begin
                r_s     <= w_sNext;
                r_carry <= w_sum[DIGIT];
                r_cnt   <= r_cnt + CW'(1);
                if (w_lastDig) begin
                    r_cout <= w_sum[DIGIT];
                    r_ovf  <= w_msbCarryIn ^ w_sum[DIGIT];
                    r_zero <= (w_sNext == '0);
                end
            end
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed bench for serial_addsub_unit: three instances (DIGIT = 4, 1, 16) share operands and reset,
// each with its own handshake lines; unit index 0/1/2 selects the instance.
module tb_serial_addsub_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] aIn;
    logic [15:0] bIn;
    logic        cinIn;
    logic        subIn;

    logic        inValid  [3];
    logic        outReady [3];
    logic        inReady  [3];
    logic        outValid [3];
    logic [15:0] sOut     [3];
    logic        coutOut  [3];
    logic        ovfOut   [3];
    logic        zeroOut  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_dig4 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .a(aIn), .b(bIn), .cin(cinIn), .sub(subIn),
        .out_valid(outValid[0]), .out_ready(outReady[0]),
        .s(sOut[0]), .cout(coutOut[0]), .ovf(ovfOut[0]), .zero(zeroOut[0])
    );

    serial_addsub_unit #(.WIDTH(16), .DIGIT(1)) u_dig1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .a(aIn), .b(bIn), .cin(cinIn), .sub(subIn),
        .out_valid(outValid[1]), .out_ready(outReady[1]),
        .s(sOut[1]), .cout(coutOut[1]), .ovf(ovfOut[1]), .zero(zeroOut[1])
    );

    serial_addsub_unit #(.WIDTH(16), .DIGIT(16)) u_dig16 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .a(aIn), .b(bIn), .cin(cinIn), .sub(subIn),
        .out_valid(outValid[2]), .out_ready(outReady[2]),
        .s(sOut[2]), .cout(coutOut[2]), .ovf(ovfOut[2]), .zero(zeroOut[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int unit, input logic [15:0] av, input logic [15:0] bv,
                                 input logic c, input logic sb);
        @(negedge clk);
        aIn           = av;
        bIn           = bv;
        cinIn         = c;
        subIn         = sb;
        inValid[unit] = 1'b1;
        @(negedge clk);
        inValid[unit] = 1'b0;
        checkOutput($sformatf("u%0d inReadyAfterAccept", unit), 32'(inReady[unit]), 32'd0);
    endtask

    // Counts edges after the accept edge until out_valid; bounded so a stuck unit cannot hang the run.
    task automatic waitResult(input int unit, input bit noise, output int lat);
        lat = 0;
        while (!outValid[unit] && lat < 100) begin
            @(negedge clk);
            lat++;
            if (noise) begin
                aIn           = 16'($urandom);
                bIn           = 16'($urandom);
                inValid[unit] = 1'($urandom);
            end
        end
    endtask

    task automatic checkResult(input int unit, input string tag, input int lat, input int expLat,
                               input logic [15:0] expS, input logic eC, input logic eO, input logic eZ);
        checkOutput($sformatf("u%0d %s latency", unit, tag), 32'(lat), 32'(expLat));
        checkOutput($sformatf("u%0d %s s", unit, tag), 32'(sOut[unit]), 32'(expS));
        checkOutput($sformatf("u%0d %s cout", unit, tag), 32'(coutOut[unit]), 32'(eC));
        checkOutput($sformatf("u%0d %s ovf", unit, tag), 32'(ovfOut[unit]), 32'(eO));
        checkOutput($sformatf("u%0d %s zero", unit, tag), 32'(zeroOut[unit]), 32'(eZ));
    endtask

    task automatic releaseResult(input int unit);
        @(negedge clk);
        inValid[unit]  = 1'b0;
        outReady[unit] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput($sformatf("u%0d outValidAfterTake", unit), 32'(outValid[unit]), 32'd0);
        checkOutput($sformatf("u%0d inReadyAfterTake", unit), 32'(inReady[unit]), 32'd1);
        outReady[unit] = 1'b0;
    endtask

    task automatic runOp(input int unit, input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic c, input logic sb, input int expLat,
                         input logic [15:0] expS, input logic eC, input logic eO, input logic eZ);
        int lat;
        applyStimulus(unit, av, bv, c, sb);
        waitResult(unit, 1'b0, lat);
        checkResult(unit, tag, lat, expLat, expS, eC, eO, eZ);
        releaseResult(unit);
    endtask

    initial begin
        int lat;
        rst_n  = 1'b0;
        aIn    = '0;
        bIn    = '0;
        cinIn  = 1'b0;
        subIn  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inValid[i]  = 1'b0;
            outReady[i] = 1'b0;
        end
        #12;
        checkOutput("resetOutValid", 32'(outValid[0]), 32'd0);
        checkOutput("resetInReady", 32'(inReady[0]), 32'd1);
        checkOutput("resetS", 32'(sOut[0]), 32'd0);
        checkOutput("resetFlags", {29'd0, coutOut[0], ovfOut[0], zeroOut[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp(0, "subNoBorrow", 16'h1234, 16'h0034, 1'b1, 1'b1, 4, 16'h1200, 1'b1, 1'b0, 1'b0);
        runOp(0, "subBorrow",   16'h0000, 16'h0001, 1'b1, 1'b1, 4, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        runOp(0, "addOvf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 4, 16'h8000, 1'b0, 1'b1, 1'b0);
        runOp(0, "addWrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 4, 16'h0000, 1'b1, 1'b0, 1'b1);
        runOp(0, "subEqual",    16'h5A5A, 16'h5A5A, 1'b1, 1'b1, 4, 16'h0000, 1'b1, 1'b0, 1'b1);
        runOp(0, "subOvf",      16'h8000, 16'h0001, 1'b1, 1'b1, 4, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Operands and in_valid churn while BUSY and DONE; the captured result must not move.
        applyStimulus(0, 16'h1234, 16'h0034, 1'b1, 1'b1);
        waitResult(0, 1'b1, lat);
        checkResult(0, "noisy", lat, 4, 16'h1200, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            aIn        = 16'($urandom);
            bIn        = 16'($urandom);
            inValid[0] = 1'($urandom);
            checkOutput($sformatf("holdOutValid%0d", i), 32'(outValid[0]), 32'd1);
            checkOutput($sformatf("holdInReady%0d", i), 32'(inReady[0]), 32'd0);
            checkOutput($sformatf("holdS%0d", i), 32'(sOut[0]), 32'h1200);
            checkOutput($sformatf("holdFlags%0d", i), {29'd0, coutOut[0], ovfOut[0], zeroOut[0]}, 32'b100);
        end
        releaseResult(0);
        @(negedge clk);
        checkOutput("noSecondAccept", 32'(inReady[0]), 32'd1);

        // Leave ovf=1 and a nonzero partial s in flight so the asynchronous clear is observable.
        runOp(0, "preReset", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4, 16'h8000, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetOutValid", 32'(outValid[0]), 32'd0);
        checkOutput("midResetS", 32'(sOut[0]), 32'd0);
        checkOutput("midResetFlags", {29'd0, coutOut[0], ovfOut[0], zeroOut[0]}, 32'd0);
        checkOutput("midResetInReady", 32'(inReady[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        runOp(0, "afterReset", 16'h0003, 16'h0001, 1'b1, 1'b1, 4, 16'h0002, 1'b1, 1'b0, 1'b0);
        runOp(1, "digit1",     16'h0003, 16'h0001, 1'b1, 1'b1, 16, 16'h0002, 1'b1, 1'b0, 1'b0);
        runOp(1, "digit1Ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        runOp(2, "digit16",    16'h0003, 16'h0001, 1'b1, 1'b1, 1, 16'h0002, 1'b1, 1'b0, 1'b0);
        runOp(2, "digit16Wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
- Parametrised multi-cycle adder/subtractor. Generalises the team's 4-bit ripple subtractor to WIDTH bits.
- Processes DIGIT bits per clock, LSB digit first, with a registered carry between digits.
- Supports add and subtract modes and produces carry, signed-overflow and zero flags.
- Sits in the ALU datapath behind a valid/ready handshake, so it can share a bus with slower units.

Parameters:
- WIDTH, 16, operand and result width in bits. Must satisfy WIDTH >= 1.
- DIGIT, 4, bits processed per cycle. Must satisfy 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0. Any other value is an elaboration error.
- NDIG, WIDTH/DIGIT, derived: the number of BUSY cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  operands present
- in_ready  output  1  unit can accept operands
- a  input  WIDTH  minuend / augend
- b  input  WIDTH  subtrahend / addend
- cin  input  1  carry into bit 0
- sub  input  1  1 = subtract (b is inverted), 0 = add
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- s  output  WIDTH  result
- cout  output  1  carry out of MSB. In subtract mode, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow
- zero  output  1  s == 0

Behaviour:
- Arithmetic: s = a + (sub ? ~b : b) + cin, modulo 2^WIDTH.
  - cin is not forced in subtract mode; the caller drives cin=1 for a true a-b.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = (s == 0), evaluated on the full final result.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0. A digit counter runs 0..NDIG-1.
  - DONE: in_ready=0, out_valid=1.
- Accept: on a clock edge with state=IDLE and in_valid=1:
  - a, b (pre-inverted if sub), cin and sub are captured.
  - The carry register is loaded with cin, the digit counter is cleared, and state becomes BUSY.
  - Input ports are ignored from then until return to IDLE.
- BUSY: each cycle adds digit[counter] of the captured operands plus the carry register.
  - The digit sum is written into s bits [counter*DIGIT +: DIGIT], and the carry register is updated.
  - After digit NDIG-1 is processed, cout, ovf and zero are registered and state becomes DONE.
- Latency: accept at edge k gives out_valid=1 from edge k+NDIG. With NDIG=1, the result appears one edge after accept.
- DONE:
  - s, cout, ovf and zero are held stable while out_valid=1 and out_ready=0, for any duration.
  - On an edge with out_ready=1, state becomes IDLE, out_valid drops and in_ready rises on the same edge.
  - No back-to-back accept occurs in DONE; the minimum issue interval is NDIG+2 cycles.
- s is undefined-but-stable during BUSY. Consumers sample it only when out_valid=1; the bench treats it as don't-care while BUSY.
- Reset: rst_n=0 forces the following asynchronously, including mid-BUSY or mid-DONE, where any operation in flight is discarded:
  - state=IDLE, counter=0, carry=0, s=0, cout=0, ovf=0, zero=0, out_valid=0.
  - in_ready=1, because it is decoded from state.
- After reset release, the first edge with in_valid=1 is accepted normally.
- in_valid and out_ready must be ignored in states where they have no effect; no X-propagation from them is allowed.

Test Plan (WIDTH=16, DIGIT=4, so NDIG=4):
- Subtract with no borrow: a=0x1234, b=0x0034, sub=1, cin=1, accept at edge k. Expect out_valid from edge k+4, s=0x1200, cout=1, ovf=0, zero=0.
- Subtract with borrow: a=0x0000, b=0x0001, sub=1, cin=1. Expect s=0xFFFF, cout=0, ovf=0, zero=0.
- Signed add overflow: a=0x7FFF, b=0x0001, sub=0, cin=0. Expect s=0x8000, cout=0, ovf=1. Then a=0xFFFF, b=0x0001, add. Expect s=0x0000, cout=1, ovf=0, zero=1.
- Equal operands: a=b=0x5A5A, sub=1, cin=1. Expect s=0x0000, zero=1, cout=1, ovf=0.
- Stability under backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid; s, flags and out_valid stay stable, and in_ready stays 0.
  - Toggle a, b and in_valid during BUSY and DONE; the result is unaffected and no second accept occurs.
  - Raise out_ready; the next edge shows out_valid=0 and in_ready=1.
- Reset mid-operation: assert rst_n=0 during BUSY cycle 2. Immediately, without waiting for a clock: out_valid=0, s=0, all flags 0, in_ready=1. After release, a fresh operation a=0x0003, b=0x0001, sub=1, cin=1 gives s=0x0002 after 4 cycles. Repeat with DIGIT=1 (expect 16-cycle latency) and DIGIT=16 (expect 1-cycle latency).
